// File: rtl/scip_cmd_tx.sv
// scip_cmd_tx: builds the 13-byte "GD" scan command for the rangefinder from two
// binary step values and shifts it out on tx as back-to-back 8N1 UART bytes.
module scip_cmd_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] start_step,
    input  logic [10:0] end_step,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [3:0]        LAST_BYTE = 4'd12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVERT   = 3'd1,
        START_BIT = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t              state_r;
    logic                tx_r;
    logic                busy_r;
    logic                done_r;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [2:0]          bit_cnt_r;
    logic [3:0]          byte_cnt_r;
    logic [7:0]          shift_r;
    // Index 0 holds start_step, index 1 end_step; digits are thousands..ones.
    logic [10:0]         val_r   [2];
    logic [3:0]          dig_r   [2][4];
    logic [1:0]          stage_r [2];

    logic [3:0]          byte_sel_s;
    logic [1:0]          dig_idx_s;
    logic [7:0]          frame_byte_s;

    function automatic logic [10:0] weight(input logic [1:0] stage);
        case (stage)
            2'd0:    weight = 11'd1000;
            2'd1:    weight = 11'd100;
            2'd2:    weight = 11'd10;
            default: weight = 11'd0;
        endcase
    endfunction

    // Select the frame byte to load next: byte 0 when leaving CONVERT, else the following byte.
    always_comb begin
        byte_sel_s   = 4'd0;
        dig_idx_s    = 2'd0;
        frame_byte_s = 8'h0A;
        if (state_r == STOP) begin
            byte_sel_s = byte_cnt_r + 4'd1;
        end else begin
            byte_sel_s = 4'd0;
        end
        dig_idx_s = byte_sel_s[1:0] - 2'd2;
        case (byte_sel_s)
            4'd0:                      frame_byte_s = 8'h47;
            4'd1:                      frame_byte_s = 8'h44;
            4'd2, 4'd3, 4'd4, 4'd5:    frame_byte_s = {4'h3, dig_r[0][dig_idx_s]};
            4'd6, 4'd7, 4'd8, 4'd9:    frame_byte_s = {4'h3, dig_r[1][dig_idx_s]};
            4'd10, 4'd11:              frame_byte_s = 8'h30;
            4'd12:                     frame_byte_s = 8'h0A;
            default:                   frame_byte_s = 8'h0A;
        endcase
    end

    // Command FSM: accept, decimal conversion, then bit-serial transmission.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 4'd0;
            shift_r    <= 8'h00;
            for (int ch = 0; ch < 2; ch++) begin
                val_r[ch]   <= 11'd0;
                stage_r[ch] <= 2'd0;
                for (int k = 0; k < 4; k++) begin
                    dig_r[ch][k] <= 4'd0;
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    tx_r   <= 1'b1;
                    done_r <= 1'b0;
                    if (start) begin
                        val_r[0] <= start_step;
                        val_r[1] <= end_step;
                        for (int ch = 0; ch < 2; ch++) begin
                            stage_r[ch] <= 2'd0;
                            for (int k = 0; k < 4; k++) begin
                                dig_r[ch][k] <= 4'd0;
                            end
                        end
                        busy_r  <= 1'b1;
                        state_r <= CONVERT;
                    end
                end
                CONVERT: begin
                    tx_r <= 1'b1;
                    // Both values convert in parallel: one subtraction or one weight step per cycle.
                    for (int ch = 0; ch < 2; ch++) begin
                        if (stage_r[ch] != 2'd3) begin
                            if (val_r[ch] >= weight(stage_r[ch])) begin
                                val_r[ch]              <= val_r[ch] - weight(stage_r[ch]);
                                dig_r[ch][stage_r[ch]] <= dig_r[ch][stage_r[ch]] + 4'd1;
                            end else begin
                                if (stage_r[ch] == 2'd2) begin
                                    dig_r[ch][3] <= val_r[ch][3:0];
                                end
                                stage_r[ch] <= stage_r[ch] + 2'd1;
                            end
                        end
                    end
                    if ((stage_r[0] == 2'd3) && (stage_r[1] == 2'd3)) begin
                        tx_r       <= 1'b0;
                        shift_r    <= frame_byte_s;
                        byte_cnt_r <= 4'd0;
                        baud_cnt_r <= '0;
                        state_r    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= 3'd0;
                        tx_r       <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt_r == BAUD_LAST) begin
                        baud_cnt_r <= '0;
                        if (byte_cnt_r == LAST_BYTE) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 4'd1;
                            shift_r    <= frame_byte_s;
                            tx_r       <= 1'b0;
                            state_r    <= START_BIT;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                DONE: begin
                    tx_r    <= 1'b1;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    tx_r    <= 1'b1;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: doc/scip_cmd_tx.md
SCIP_CMD_TX -- requirements
Module: scip_cmd_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit cell (115200 baud at 100 MHz).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to send one scan command, sampled each clk.
REQ-005 SHALL have port start_step, input, 11, first scan step (binary), latched on accept.
REQ-006 SHALL have port end_step, input, 11, last scan step (binary), latched on accept.
REQ-007 SHALL have port tx, output, 1, UART serial line to the rangefinder, idle high.
REQ-008 SHALL have port busy, output, 1, high from accept until the done pulse.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the frame has fully left tx.

Function
REQ-010 SHALL accept start only when busy=0; busy rises on the cycle after accept.
REQ-011 SHALL ignore start while busy=1, with no queuing.
REQ-012 SHALL send a fixed 13-byte frame: 'G'(0x47), 'D'(0x44), 4 ASCII decimal digits of start_step, 4 ASCII decimal digits of end_step, '0','0' (cluster count), then LF (0x0A).
REQ-013 SHALL emit decimal digits most-significant first, zero-padded to 4 digits, each digit = 0x30 + value; for example 768 -> "0768".
REQ-014 SHALL convert binary to decimal by sequential repeated subtraction of 1000, 100 and 10, using no divider.
REQ-015 SHALL complete both conversions before the first start bit, and SHALL drive the first start bit no more than 48 cycles after accept.
REQ-016 SHALL send each byte as 8N1: start bit 0, data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-017 SHALL send bytes back-to-back: the next start bit follows the previous stop bit with no idle cycles.
REQ-018 SHALL use the states IDLE, CONVERT, START_BIT, DATA, STOP, DONE.
REQ-019 SHALL make these transitions: IDLE->CONVERT on accept; CONVERT->START_BIT when conversion is complete; START_BIT->DATA after one bit cell; DATA->STOP after 8 bit cells; STOP->START_BIT if bytes remain, else STOP->DONE; DONE->IDLE after one cycle.
REQ-020 SHALL assert done for exactly one cycle in DONE and clear busy on the same cycle's exit, so start is acceptable on the cycle after done.
REQ-021 SHALL hold tx=1 in IDLE, CONVERT and DONE.
REQ-022 SHALL register tx with no glitches.
REQ-023 SHALL not range-check step values: any 11-bit value up to 2047 is sent as 4 digits, and start_step > end_step is sent unchanged.
REQ-024 SHALL keep latched values unaffected by changes on start_step or end_step after accept.

Reset
REQ-025 SHALL, on reset assertion (asynchronous, mid-frame included), immediately force tx=1, busy=0 and done=0, return to IDLE, and clear byte, bit and baud counters.
REQ-026 SHALL ignore start while reset is high, and SHALL accept start on the first clk edge after reset deasserts.

Verification
REQ-027 SHALL be verified by: CLKS_PER_BIT=4, start_step=0, end_step=768, pulse start -> tx decodes to 47 44 30 30 30 30 30 37 36 38 30 30 0A, with done pulsing once after the final stop bit.
REQ-028 SHALL be verified by: start_step=5, end_step=2047 -> digit bytes "0005" and "2047"; start_step=1080, end_step=1000 -> "1080" and "1000" sent unchanged.
REQ-029 SHALL be verified by: start held high continuously -> frames occur back-to-back, separated only by DONE and the CONVERT latency, and start pulses mid-frame have no effect.
REQ-030 SHALL be verified by: reset asserted during the DATA phase of byte 6 -> tx=1 and busy=0 without waiting for a clk edge, and a new start produces a complete, correct frame.
REQ-031 SHALL be verified by: CLKS_PER_BIT=868, each bit cell measured at 868 cycles (±0), with the first start bit no more than 48 cycles after accept.
REQ-032 SHALL be verified by: step inputs changed on the cycle after accept -> the frame carries the originally latched values.
